// File: rtl/fpmul_pkg.sv
// Shared FP32 field layout and the stage-2 response record for the fpmul_sched multiplier scheduler.
package fpmul_pkg;

   localparam int FP_W        = 32;
   localparam int FP_SIGN_BIT = 31;
   localparam int FP_EXP_MSB  = 30;
   localparam int FP_EXP_LSB  = 23;
   localparam int FP_EXP_W    = 8;
   localparam int FP_FRAC_W   = 23;
   localparam int FP_BIAS     = 127;
   localparam logic [FP_EXP_W-1:0] FP_EXP_MAX = 8'hFF;

   localparam int NREQ_MAX  = 8;
   localparam int TAG_MAX_W = $clog2(NREQ_MAX);

   typedef struct packed {
      logic [FP_W-1:0]      result;
      logic                 overflow;
      logic                 underflow;
      logic [TAG_MAX_W-1:0] tag;
   } rsp_t;

   function automatic logic [FP_W-1:0] fp_pack(input logic s,
                                               input logic [FP_EXP_W-1:0] e,
                                               input logic [FP_FRAC_W-1:0] f);
      return {s, e, f};
   endfunction

endpackage

// File: rtl/fpmul_sched_if.sv
// Request/response bundle for fpmul_sched: NREQ operand channels in, one tagged product channel out.
interface fpmul_sched_if #(
   parameter int NREQ = 4,
   parameter int TAGW = $clog2(NREQ)
);
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ-1:0][31:0] req_a;
   logic [NREQ-1:0][31:0] req_b;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [31:0]           rsp_result;
   logic                  rsp_overflow;
   logic                  rsp_underflow;
   logic [TAGW-1:0]       rsp_tag;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_result, rsp_overflow, rsp_underflow, rsp_tag
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_result, rsp_overflow, rsp_underflow, rsp_tag
   );
endinterface

// File: rtl/fpmul_rr_arb.sv
// Round-robin arbiter: searches from ptr upward (mod NREQ), returns a one-hot grant and the pointer
// to use after an accepted transfer.
module fpmul_rr_arb #(
   parameter int NREQ = 4,
   parameter int TAGW = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [TAGW-1:0] ptr_i,
   input  logic            advance_i,
   output logic [NREQ-1:0] grant_o,
   output logic [TAGW-1:0] gidx_o,
   output logic [TAGW-1:0] ptr_nxt_o
);

   logic            found_s;
   logic            hit_s;
   logic [TAGW-1:0] idx_s;

   // first asserted request at or after ptr wins
   always_comb begin
      grant_o = '0;
      gidx_o  = '0;
      found_s = 1'b0;
      hit_s   = 1'b0;
      idx_s   = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx_s          = TAGW'((int'(ptr_i) + k) % NREQ);
         hit_s          = !found_s && req_i[idx_s];
         grant_o[idx_s] = grant_o[idx_s] | hit_s;
         gidx_o         = hit_s ? idx_s : gidx_o;
         found_s        = found_s | hit_s;
      end
   end

   // pointer moves past the winner only when its transfer actually happens
   always_comb begin
      ptr_nxt_o = ptr_i;
      if (advance_i) begin
         if (gidx_o == TAGW'(NREQ - 1)) begin
            ptr_nxt_o = '0;
         end else begin
            ptr_nxt_o = gidx_o + TAGW'(1);
         end
      end else begin
         ptr_nxt_o = ptr_i;
      end
   end

endmodule

// File: rtl/mult.sv
// Combinational FP32 multiplier (truncating, no special-value handling) with overflow/underflow flags.
module mult
   import fpmul_pkg::*;
(
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [31:0] result_o,
   output logic        overflow_o,
   output logic        underflow_o
);

   logic                 sign_s;
   logic [23:0]          man_a_s;
   logic [23:0]          man_b_s;
   logic [47:0]          prod_s;
   logic signed [9:0]    exp_s;
   logic [FP_FRAC_W-1:0] frac_s;

   assign sign_s  = a_i[FP_SIGN_BIT] ^ b_i[FP_SIGN_BIT];
   // hidden bit is present only for a non-zero exponent field
   assign man_a_s = {|a_i[FP_EXP_MSB:FP_EXP_LSB], a_i[FP_FRAC_W-1:0]};
   assign man_b_s = {|b_i[FP_EXP_MSB:FP_EXP_LSB], b_i[FP_FRAC_W-1:0]};
   assign prod_s  = {24'd0, man_a_s} * {24'd0, man_b_s};
   assign exp_s   = $signed({2'b00, a_i[FP_EXP_MSB:FP_EXP_LSB]})
                  + $signed({2'b00, b_i[FP_EXP_MSB:FP_EXP_LSB]})
                  - 10'sd127
                  + $signed({9'd0, prod_s[47]});
   assign frac_s  = prod_s[47] ? prod_s[46:24] : prod_s[45:23];

   // classify and assemble the product
   always_comb begin
      result_o    = 32'd0;
      overflow_o  = 1'b0;
      underflow_o = 1'b0;
      if (prod_s == 48'd0) begin
         result_o = fp_pack(sign_s, 8'd0, 23'd0);
      end else if (exp_s > 10'sd254) begin
         overflow_o = 1'b1;
         result_o   = fp_pack(sign_s, FP_EXP_MAX, 23'd0);
      end else if (exp_s < 10'sd1) begin
         underflow_o = 1'b1;
         result_o    = fp_pack(sign_s, 8'd0, 23'd0);
      end else begin
         result_o = fp_pack(sign_s, exp_s[7:0], frac_s);
      end
   end

endmodule

// File: rtl/fpmul_sched.sv
// Round-robin scheduler sharing one FP32 multiplier among NREQ requesters via a two-stage pipeline.
// Optional response statistics counters are built when FPMUL_SCHED_STATS_EN is defined.
module fpmul_sched
   import fpmul_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int TAGW = $clog2(NREQ)
) (
   input  logic             clk,
   input  logic             rst_n,
   fpmul_sched_if.slave     bus
`ifdef FPMUL_SCHED_STATS_EN
   ,
   output logic [31:0]      stat_ops,
   output logic [15:0]      stat_ovf,
   output logic [15:0]      stat_unf
`endif
);

   logic [NREQ-1:0] grant_s;
   logic [NREQ-1:0] ready_s;
   logic [TAGW-1:0] gidx_s;
   logic [TAGW-1:0] ptr_d;
   logic [TAGW-1:0] ptr_q;
   logic            en_s;
   logic            accept_s;

   logic            s1_valid_q;
   logic [31:0]     s1_a_q;
   logic [31:0]     s1_b_q;
   logic [TAGW-1:0] s1_tag_q;
   logic            s2_valid_q;
   rsp_t            s2_q;

   logic [31:0]     mul_res_s;
   logic            mul_ovf_s;
   logic            mul_unf_s;

   // rst_n gating keeps every req_ready low while reset is held
   assign en_s          = !s2_valid_q || bus.rsp_ready;
   assign ready_s       = grant_s & {NREQ{en_s & rst_n}};
   assign accept_s      = |(bus.req_valid & ready_s);
   assign bus.req_ready = ready_s;

   fpmul_rr_arb #(.NREQ(NREQ), .TAGW(TAGW)) u_arb (
      .req_i     (bus.req_valid),
      .ptr_i     (ptr_q),
      .advance_i (accept_s),
      .grant_o   (grant_s),
      .gidx_o    (gidx_s),
      .ptr_nxt_o (ptr_d)
   );

   mult u_mult (
      .a_i         (s1_a_q),
      .b_i         (s1_b_q),
      .result_o    (mul_res_s),
      .overflow_o  (mul_ovf_s),
      .underflow_o (mul_unf_s)
   );

   // arbitration pointer and both pipeline stages; a stall freezes everything
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q      <= '0;
         s1_valid_q <= 1'b0;
         s1_a_q     <= 32'd0;
         s1_b_q     <= 32'd0;
         s1_tag_q   <= '0;
         s2_valid_q <= 1'b0;
         s2_q       <= '0;
      end else begin
         ptr_q <= ptr_d;
         if (en_s) begin
            s1_valid_q     <= accept_s;
            s1_a_q         <= bus.req_a[gidx_s];
            s1_b_q         <= bus.req_b[gidx_s];
            s1_tag_q       <= gidx_s;
            s2_valid_q     <= s1_valid_q;
            s2_q.result    <= mul_res_s;
            s2_q.overflow  <= mul_ovf_s;
            s2_q.underflow <= mul_unf_s;
            s2_q.tag       <= TAG_MAX_W'(s1_tag_q);
         end
      end
   end

   assign bus.rsp_valid     = s2_valid_q;
   assign bus.rsp_result    = s2_q.result;
   assign bus.rsp_overflow  = s2_q.overflow;
   assign bus.rsp_underflow = s2_q.underflow;
   assign bus.rsp_tag       = s2_q.tag[TAGW-1:0];

`ifdef FPMUL_SCHED_STATS_EN
   logic        rsp_fire_s;
   logic [31:0] stat_ops_q;
   logic [15:0] stat_ovf_q;
   logic [15:0] stat_unf_q;

   assign rsp_fire_s = s2_valid_q && bus.rsp_ready;

   // saturating counters of delivered responses and their flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_ops_q <= 32'd0;
         stat_ovf_q <= 16'd0;
         stat_unf_q <= 16'd0;
      end else if (rsp_fire_s) begin
         if (stat_ops_q != 32'hFFFF_FFFF) begin
            stat_ops_q <= stat_ops_q + 32'd1;
         end
         if (s2_q.overflow && (stat_ovf_q != 16'hFFFF)) begin
            stat_ovf_q <= stat_ovf_q + 16'd1;
         end
         if (s2_q.underflow && (stat_unf_q != 16'hFFFF)) begin
            stat_unf_q <= stat_unf_q + 16'd1;
         end
      end
   end

   assign stat_ops = stat_ops_q;
   assign stat_ovf = stat_ovf_q;
   assign stat_unf = stat_unf_q;
`endif

endmodule

// File: tb/tb_fpmul_sched.sv
// Scoreboard bench for fpmul_sched: expected products are queued on acceptance and matched in order
// against the response channel. Stats checks are compiled when FPMUL_SCHED_STATS_EN is defined.
module tb_fpmul_sched;

   localparam int NREQ = 4;
   localparam int TAGW = 2;

   typedef struct packed {
      logic [31:0]     res;
      logic            ovf;
      logic            unf;
      logic            chk_res;
      logic [TAGW-1:0] tag;
   } exp_t;

   logic clk;
   logic rst_n;

   fpmul_sched_if #(.NREQ(NREQ)) bus();

`ifdef FPMUL_SCHED_STATS_EN
   logic [31:0] stat_ops;
   logic [15:0] stat_ovf;
   logic [15:0] stat_unf;
`endif

   fpmul_sched #(.NREQ(NREQ)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
`ifdef FPMUL_SCHED_STATS_EN
      ,
      .stat_ops (stat_ops),
      .stat_ovf (stat_ovf),
      .stat_unf (stat_unf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t            sb[$];
   exp_t            pend[NREQ];
   exp_t            mon_e;
   int              acc_log[$];
   int unsigned     seq[NREQ];
   logic [NREQ-1:0] stream_mask;
   logic [NREQ-1:0] hs;
   int              rsp_cnt;
   int              n_tests;
   int              n_fail;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, want);
      end
   endtask

   // monitor: push on request transfer, pop and compare on response transfer
   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < NREQ; i++) begin
            if (bus.req_valid[i] && bus.req_ready[i]) begin
               mon_e     = pend[i];
               mon_e.tag = TAGW'(i);
               sb.push_back(mon_e);
               acc_log.push_back(i);
            end
         end
         if (bus.rsp_valid && bus.rsp_ready) begin
            rsp_cnt++;
            if (sb.size() == 0) begin
               check("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
            end else begin
               mon_e = sb.pop_front();
               if (mon_e.chk_res) check("rsp_result", bus.rsp_result, mon_e.res);
               check("rsp_overflow", 32'(bus.rsp_overflow), 32'(mon_e.ovf));
               check("rsp_underflow", 32'(bus.rsp_underflow), 32'(mon_e.unf));
               check("rsp_tag", 32'(bus.rsp_tag), 32'(mon_e.tag));
            end
         end
      end
   end

   // stream op k on requester i: 2^(k%8) * 3.0 = 3.0 * 2^(k%8), exact
   task automatic load_op(input int i);
      logic [7:0] e;
      e = 8'(seq[i] % 32'd8);
      bus.req_a[i]     = {1'b0, 8'd127 + e, 23'd0};
      bus.req_b[i]     = 32'h4040_0000;
      pend[i]          = '{res: {1'b0, 8'd128 + e, 23'h40_0000}, ovf: 1'b0, unf: 1'b0,
                           chk_res: 1'b1, tag: '0};
      bus.req_valid[i] = 1'b1;
      seq[i]++;
   endtask

   task automatic step();
      @(negedge clk);
      hs = bus.req_valid & bus.req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
         if (hs[i] || !bus.req_valid[i]) begin
            if (stream_mask[i]) load_op(i);
            else bus.req_valid[i] = 1'b0;
         end
      end
   endtask

   task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic ovf, input logic unf, input logic chk);
      logic got;
      bus.req_a[i]     = a;
      bus.req_b[i]     = b;
      pend[i]          = '{res: res, ovf: ovf, unf: unf, chk_res: chk, tag: '0};
      bus.req_valid[i] = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 50 && !got; c++) begin
         step();
         got = hs[i];
      end
      check("issue_accept", 32'(got), 32'd1);
   endtask

   task automatic drain();
      stream_mask = '0;
      for (int c = 0; c < 40; c++) begin
         if (bus.req_valid == '0 && sb.size() == 0) break;
         step();
      end
   endtask

   logic [31:0]     hold_res;
   logic [TAGW-1:0] hold_tag;
   int              cnt0;
   int              got_j;

   initial begin
      n_tests = 0;
      n_fail = 0;
      rsp_cnt = 0;
      stream_mask = '0;
      hs = '0;
      for (int i = 0; i < NREQ; i++) begin
         seq[i]  = 0;
         pend[i] = '0;
      end
      rst_n = 1'b0;
      bus.req_valid = 4'b0001;
      bus.req_a = '0;
      bus.req_b = '0;
      bus.rsp_ready = 1'b1;

      // reset state, with a pending request that must not be readied
      #22;
      check("rst_req_ready", 32'(bus.req_ready), 32'd0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_rsp_result", bus.rsp_result, 32'd0);
      check("rst_rsp_flags", 32'({bus.rsp_overflow, bus.rsp_underflow}), 32'd0);
      check("rst_rsp_tag", 32'(bus.rsp_tag), 32'd0);
      bus.req_valid = '0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      step();

      // single op 2.0 * 3.0 on requester 0 with latency check
      bus.req_a[0] = 32'h4000_0000;
      bus.req_b[0] = 32'h4040_0000;
      pend[0] = '{res: 32'h40C0_0000, ovf: 1'b0, unf: 1'b0, chk_res: 1'b1, tag: '0};
      bus.req_valid[0] = 1'b1;
      step();
      check("single_grant", 32'(hs), 32'd1);
      check("lat_stage1", 32'(bus.rsp_valid), 32'd0);
      step();
      check("lat_stage2", 32'(bus.rsp_valid), 32'd1);
      check("single_result", bus.rsp_result, 32'h40C0_0000);
      step();
      check("single_once", 32'(bus.rsp_valid), 32'd0);

      // contention: all four valid continuously; last winner was 0 so order starts at 1
      acc_log.delete();
      stream_mask = 4'b1111;
      for (int s = 0; s < 11; s++) begin
         step();
         if (s >= 3) check("cont_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      end
      for (int j = 0; j < 8; j++) begin
         got_j = (j < acc_log.size()) ? acc_log[j] : -1;
         check("cont_order", 32'(got_j), 32'((1 + j) % 4));
      end
      drain();

      // backpressure on a requester-1 stream
      stream_mask = 4'b0010;
      repeat (4) step();
      bus.rsp_ready = 1'b0;
      hold_res = bus.rsp_result;
      hold_tag = bus.rsp_tag;
      for (int s = 0; s < 3; s++) begin
         step();
         check("bp_req_ready", 32'(bus.req_ready), 32'd0);
         check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
         check("bp_rsp_result", bus.rsp_result, hold_res);
         check("bp_rsp_tag", 32'(bus.rsp_tag), 32'(hold_tag));
      end
      bus.rsp_ready = 1'b1;
      drain();

      // overflow and underflow
      issue(2, 32'h7F00_0000, 32'h7F00_0000, 32'd0, 1'b1, 1'b0, 1'b0);
      issue(2, 32'h0080_0000, 32'h0080_0000, 32'd0, 1'b0, 1'b1, 1'b0);
      drain();

      // reset mid-flight with both stages busy
      stream_mask = 4'b0010;
      repeat (4) step();
      check("pre_rst_valid", 32'(bus.rsp_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("midrst_req_ready", 32'(bus.req_ready), 32'd0);
      sb.delete();
      stream_mask = '0;
      bus.req_valid = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      cnt0 = rsp_cnt;
      repeat (5) step();
      check("rst_no_rsp", 32'(rsp_cnt - cnt0), 32'd0);

      // after reset requester 0 wins over requester 2
      bus.req_a[0] = 32'h4000_0000;
      bus.req_b[0] = 32'h4040_0000;
      pend[0] = '{res: 32'h40C0_0000, ovf: 1'b0, unf: 1'b0, chk_res: 1'b1, tag: '0};
      bus.req_a[2] = 32'h7F00_0000;
      bus.req_b[2] = 32'h7F00_0000;
      pend[2] = '{res: 32'd0, ovf: 1'b1, unf: 1'b0, chk_res: 1'b0, tag: '0};
      bus.req_valid = 4'b0101;
      step();
      check("rst_grant", 32'(hs), 32'd1);
      drain();
      issue(1, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 1'b0, 1'b0, 1'b1);
      issue(1, 32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000, 1'b0, 1'b0, 1'b1);
      issue(1, 32'h3F00_0000, 32'h4080_0000, 32'h4000_0000, 1'b0, 1'b0, 1'b1);
      drain();
      repeat (3) step();

`ifdef FPMUL_SCHED_STATS_EN
      check("stat_ops", stat_ops, 32'd5);
      check("stat_ovf", 32'(stat_ovf), 32'd1);
      check("stat_unf", 32'(stat_unf), 32'd0);
`endif

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
